gat_load_ctrl: RTL and testbench

- Multi-channel load/launch controller between the AXI BRAM controller ports (byte-addressed, TOP_WIDTH data) and the GAT core's word-addressed BRAM write ports.
- Registers and forwards each channel's writes to word addresses, rejects misaligned writes, and counts accepted words per channel.
- Collects per-channel load-done strobes, launches the core with a single-cycle start, then raises gat_ready when the core reports done.

---
 rtl/gat_pkg.sv | 28 ++
 rtl/gat_load_ctrl_if.sv | 24 ++
 rtl/gat_load_ch.sv | 63 ++++++
 rtl/gat_load_ctrl.sv | 117 +++++++++++
 tb/tb_gat_load_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gat_pkg.sv
// Shared types and status-word layout for the GAT load/launch controller.
package gat_pkg;

    typedef enum logic [2:0] {
        GAT_LD_IDLE  = 3'd0,
        GAT_LD_LOAD  = 3'd1,
        GAT_LD_WAIT  = 3'd2,
        GAT_LD_START = 3'd3,
        GAT_LD_RUN   = 3'd4,
        GAT_LD_DONE  = 3'd5
    } gat_load_state_t;

    localparam int GAT_ST_STATE_W = 3;

    // Status word packs fields from the MSB down: state, err_busy, err_align.
    function automatic int gat_st_state_lsb(input int top_w);
        return top_w - GAT_ST_STATE_W;
    endfunction

    function automatic int gat_st_busy_lsb(input int top_w, input int n_ch);
        return top_w - GAT_ST_STATE_W - n_ch;
    endfunction

    function automatic int gat_st_align_lsb(input int top_w, input int n_ch);
        return top_w - GAT_ST_STATE_W - 2 * n_ch;
    endfunction

endpackage

// File: rtl/gat_load_ctrl_if.sv
// Byte-addressed BRAM-controller side in, word-addressed core BRAM write side out.
interface gat_load_ctrl_if #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 22
);
    logic [NUM_CH*TOP_WIDTH-1:0]  bus_din;
    logic [NUM_CH-1:0]            bus_ena;
    logic [NUM_CH-1:0]            bus_wea;
    logic [NUM_CH*ADDR_W-1:0]     bus_addra;
    logic [NUM_CH*TOP_WIDTH-1:0]  core_din;
    logic [NUM_CH-1:0]            core_wea;
    logic [NUM_CH*(ADDR_W-2)-1:0] core_addra;

    modport master (
        output bus_din, bus_ena, bus_wea, bus_addra,
        input  core_din, core_wea, core_addra
    );

    modport slave (
        input  bus_din, bus_ena, bus_wea, bus_addra,
        output core_din, core_wea, core_addra
    );
endinterface

// File: rtl/gat_load_ch.sv
// One load channel: alignment check, registered write forwarding, saturating word counter.
module gat_load_ch #(
    parameter int TOP_WIDTH = 32,
    parameter int ADDR_W    = 22,
    parameter int CNT_W     = ADDR_W - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TOP_WIDTH-1:0] din_i,
    input  logic                 ena_i,
    input  logic                 wea_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 accept_en_i,
    input  logic                 cnt_clr_i,
    output logic                 wr_valid_o,
    output logic                 wr_ok_o,
    output logic                 wr_misalign_o,
    output logic                 wr_acc_o,
    output logic [TOP_WIDTH-1:0] core_din_o,
    output logic                 core_wea_o,
    output logic [ADDR_W-3:0]    core_addra_o,
    output logic [CNT_W-1:0]     cnt_o
);
    logic [TOP_WIDTH-1:0] din_q;
    logic                 wea_q;
    logic [ADDR_W-3:0]    addr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign wr_valid_o    = ena_i & wea_i;
    assign wr_ok_o       = wr_valid_o & (addr_i[1:0] == 2'b00);
    assign wr_misalign_o = wr_valid_o & (addr_i[1:0] != 2'b00);
    assign wr_acc_o      = wr_ok_o & accept_en_i;

    // A clear coincides with the write that restarts a load, so it counts as 1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
            cnt_d = wr_acc_o ? CNT_W'(1) : '0;
        else if (wr_acc_o && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= '0;
            wea_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wea_q <= wr_acc_o;
            cnt_q <= cnt_d;
            if (wr_acc_o) begin
                din_q  <= din_i;
                addr_q <= addr_i[ADDR_W-1:2];
            end
        end
    end

    assign core_din_o   = din_q;
    assign core_wea_o   = wea_q;
    assign core_addra_o = addr_q;
    assign cnt_o        = cnt_q;
endmodule

// File: rtl/gat_load_ctrl.sv
// Multi-channel load/launch controller: forwards channel writes to the core BRAMs,
// waits for every channel's load-done, pulses core_start and reports completion.
module gat_load_ctrl
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 22,
    parameter int CNT_W     = ADDR_W - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gat_load_ctrl_if.slave          bus,
    input  logic [NUM_CH-1:0]       load_done,
    output logic                    core_start,
    input  logic                    core_done,
    output logic                    gat_ready,
    output logic [TOP_WIDTH-1:0]    gat_status,
    output logic [NUM_CH*CNT_W-1:0] word_cnt
);
    localparam int ST_LSB    = gat_st_state_lsb(TOP_WIDTH);
    localparam int BUSY_LSB  = gat_st_busy_lsb(TOP_WIDTH, NUM_CH);
    localparam int ALIGN_LSB = gat_st_align_lsb(TOP_WIDTH, NUM_CH);
    localparam int CNT_FIT   = (CNT_W < ALIGN_LSB) ? CNT_W : ALIGN_LSB;

    gat_load_state_t state_q, state_d;
    logic [NUM_CH-1:0] done_seen_q, done_seen_d;
    logic [NUM_CH-1:0] ld_prev_q;
    logic [NUM_CH-1:0] err_busy_q, err_busy_d;
    logic [NUM_CH-1:0] err_align_q, err_align_d;
    logic [NUM_CH-1:0] wr_valid, wr_ok, wr_misalign, wr_acc, ld_rise;
    logic              leave_done, accept_en;

    logic [NUM_CH*TOP_WIDTH-1:0]  core_din_w;
    logic [NUM_CH-1:0]            core_wea_w;
    logic [NUM_CH*(ADDR_W-2)-1:0] core_addra_w;

    // Leaving DONE reopens acceptance in the same cycle, so that write is not lost.
    assign ld_rise    = load_done & ~ld_prev_q;
    assign leave_done = (state_q == GAT_LD_DONE) && ((|wr_ok) || (|ld_rise));
    assign accept_en  = (state_q == GAT_LD_IDLE) || (state_q == GAT_LD_LOAD) || leave_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            gat_load_ch #(
                .TOP_WIDTH (TOP_WIDTH),
                .ADDR_W    (ADDR_W),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .din_i         (bus.bus_din[gi*TOP_WIDTH +: TOP_WIDTH]),
                .ena_i         (bus.bus_ena[gi]),
                .wea_i         (bus.bus_wea[gi]),
                .addr_i        (bus.bus_addra[gi*ADDR_W +: ADDR_W]),
                .accept_en_i   (accept_en),
                .cnt_clr_i     (leave_done),
                .wr_valid_o    (wr_valid[gi]),
                .wr_ok_o       (wr_ok[gi]),
                .wr_misalign_o (wr_misalign[gi]),
                .wr_acc_o      (wr_acc[gi]),
                .core_din_o    (core_din_w[gi*TOP_WIDTH +: TOP_WIDTH]),
                .core_wea_o    (core_wea_w[gi]),
                .core_addra_o  (core_addra_w[gi*(ADDR_W-2) +: (ADDR_W-2)]),
                .cnt_o         (word_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.core_din   = core_din_w;
    assign bus.core_wea   = core_wea_w;
    assign bus.core_addra = core_addra_w;

    always_comb begin
        state_d     = state_q;
        done_seen_d = leave_done ? load_done : (done_seen_q | load_done);
        err_align_d = err_align_q | (wr_misalign & {NUM_CH{accept_en}});
        err_busy_d  = err_busy_q | (wr_valid & {NUM_CH{~accept_en}});
        case (state_q)
            GAT_LD_IDLE:  if ((|wr_acc) || (|load_done)) state_d = GAT_LD_LOAD;
            GAT_LD_LOAD:  if (&(done_seen_q | load_done)) state_d = GAT_LD_WAIT;
            GAT_LD_WAIT:  state_d = GAT_LD_START;
            GAT_LD_START: state_d = GAT_LD_RUN;
            GAT_LD_RUN:   if (core_done) state_d = GAT_LD_DONE;
            GAT_LD_DONE:  if (leave_done) state_d = GAT_LD_LOAD;
            default:      state_d = GAT_LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GAT_LD_IDLE;
            done_seen_q <= '0;
            ld_prev_q   <= '0;
            err_busy_q  <= '0;
            err_align_q <= '0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            ld_prev_q   <= load_done;
            err_busy_q  <= err_busy_d;
            err_align_q <= err_align_d;
        end
    end

    assign core_start = (state_q == GAT_LD_START);
    assign gat_ready  = (state_q == GAT_LD_DONE);

    always_comb begin
        gat_status                             = '0;
        gat_status[ST_LSB +: GAT_ST_STATE_W]   = state_q;
        gat_status[BUSY_LSB +: NUM_CH]         = err_busy_q;
        gat_status[ALIGN_LSB +: NUM_CH]        = err_align_q;
        gat_status[CNT_FIT-1:0]                = word_cnt[CNT_FIT-1:0];
    end
endmodule

// File: tb/tb_gat_load_ctrl.sv
// Randomized and directed check of gat_load_ctrl against a cycle-level behavioural model.
module tb_gat_load_ctrl;
    localparam int TW = 32;
    localparam int N  = 3;
    localparam int AW = 6;
    localparam int CW = AW - 1;
    localparam int WA = AW - 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_START = 3, S_RUN = 4, S_DONE = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] ld = '0;
    logic cd = 1'b0;
    logic core_start, gat_ready;
    logic [TW-1:0] gat_status;
    logic [N*CW-1:0] word_cnt;

    int total = 0;
    int bad = 0;

    gat_load_ctrl_if #(.TOP_WIDTH(TW), .NUM_CH(N), .ADDR_W(AW)) bif ();

    gat_load_ctrl #(.TOP_WIDTH(TW), .NUM_CH(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif.slave),
        .load_done  (ld),
        .core_start (core_start),
        .core_done  (cd),
        .gat_ready  (gat_ready),
        .gat_status (gat_status),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_st;
    bit [N-1:0] m_seen, m_prev, m_eb, m_ea, m_wea;
    int m_cnt [N];
    logic [WA-1:0] m_addr [N];
    logic [TW-1:0] m_din [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_seen = '0; m_prev = '0; m_eb = '0; m_ea = '0; m_wea = '0;
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0; m_addr[c] = '0; m_din[c] = '0;
        end
    endtask

    task automatic model_step();
        bit [N-1:0] valid, aligned, acc, rise;
        bit leave, phase;
        int a;
        for (int c = 0; c < N; c++) begin
            valid[c]   = bif.bus_ena[c] && bif.bus_wea[c];
            a          = int'(bif.bus_addra[c*AW +: AW]);
            aligned[c] = (a % 4) == 0;
        end
        rise  = ld & ~m_prev;
        leave = (m_st == S_DONE) && (((valid & aligned) != 0) || rise != 0);
        phase = (m_st == S_IDLE) || (m_st == S_LOAD) || leave;
        for (int c = 0; c < N; c++) begin
            acc[c] = valid[c] && aligned[c] && phase;
            if (valid[c] && !aligned[c] && phase) m_ea[c] = 1'b1;
            if (valid[c] && !phase) m_eb[c] = 1'b1;
            if (leave) m_cnt[c] = acc[c] ? 1 : 0;
            else if (acc[c] && m_cnt[c] < CMAX) m_cnt[c]++;
            m_wea[c] = acc[c];
            if (acc[c]) begin
                m_addr[c] = WA'(int'(bif.bus_addra[c*AW +: AW]) / 4);
                m_din[c]  = bif.bus_din[c*TW +: TW];
            end
        end
        case (m_st)
            S_IDLE:  if (acc != 0 || ld != 0) m_st = S_LOAD;
            S_LOAD:  if ((m_seen | ld) == {N{1'b1}}) m_st = S_WAIT;
            S_WAIT:  m_st = S_START;
            S_START: m_st = S_RUN;
            S_RUN:   if (cd) m_st = S_DONE;
            S_DONE:  if (leave) m_st = S_LOAD;
            default: m_st = S_IDLE;
        endcase
        m_seen = leave ? ld : (m_seen | ld);
        m_prev = ld;
    endtask

    task automatic compare_all();
        logic [TW-1:0] es;
        logic [N*CW-1:0] ec;
        es = {3'(m_st), m_eb, m_ea, {(TW-9-CW){1'b0}}, CW'(m_cnt[0])};
        for (int c = 0; c < N; c++) ec[c*CW +: CW] = CW'(m_cnt[c]);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("core_wea%0d", c), bif.core_wea[c], m_wea[c]);
            chk($sformatf("core_addra%0d", c), bif.core_addra[c*WA +: WA], m_addr[c]);
            chk($sformatf("core_din%0d", c), bif.core_din[c*TW +: TW], m_din[c]);
        end
        chk("word_cnt", word_cnt, ec);
        chk("gat_status", gat_status, es);
        chk("core_start", core_start, m_st == S_START);
        chk("gat_ready", gat_ready, m_st == S_DONE);
    endtask

    task automatic set_idle();
        bif.bus_ena = '0; bif.bus_wea = '0; ld = '0; cd = 1'b0;
    endtask

    task automatic wr(input int c, input int addr, input logic [TW-1:0] din);
        bif.bus_ena[c] = 1'b1;
        bif.bus_wea[c] = 1'b1;
        bif.bus_addra[c*AW +: AW] = AW'(addr);
        bif.bus_din[c*TW +: TW] = din;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bif.bus_din = '0; bif.bus_addra = '0;
        set_idle();
        do_reset();
        chk("rst_status", gat_status, 0);
        chk("rst_cnt", word_cnt, 0);

        // First aligned write lands one cycle later as a word address
        wr(0, 'h10, 'hAB); cycle(); set_idle();
        chk("t1_wea0", bif.core_wea[0], 1);
        chk("t1_addr0", bif.core_addra[WA-1:0], 'h4);
        chk("t1_din0", bif.core_din[TW-1:0], 'hAB);
        chk("t1_cnt0", word_cnt[CW-1:0], 1);
        chk("t1_state", gat_status[31:29], S_LOAD);

        wr(1, 'h6, 'h12); cycle(); set_idle();
        chk("t2_wea1", bif.core_wea[1], 0);
        chk("t2_ealign1", gat_status[24], 1);
        chk("t2_cnt1", word_cnt[2*CW-1:CW], 0);

        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < N; c++) wr(c, 4 * (k + 1), TW'($urandom));
            cycle();
            set_idle();
        end
        ld = 3'b100; cycle(); ld = 3'b001; cycle();
        chk("t3_still_load", gat_status[31:29], S_LOAD);
        ld = 3'b010; cycle(); set_idle();
        chk("t3_wait", gat_status[31:29], S_WAIT);
        chk("t3_nostart", core_start, 0);
        cycle();
        chk("t3_start", core_start, 1);
        chk("t3_notready", gat_ready, 0);
        cd = 1'b1; cycle(); cd = 1'b0;
        chk("t3_start_once", core_start, 0);
        chk("t3_run_ignores_done", gat_status[31:29], S_RUN);

        wr(2, 'h8, 'h99); cycle(); set_idle();
        chk("t4_ebusy2", gat_status[28], 1);
        chk("t4_nowea2", bif.core_wea[2], 0);
        cd = 1'b1; cycle(); cd = 1'b0;
        chk("t4_ready", gat_ready, 1);
        cycle(); cycle();
        chk("t4_ready_hold", gat_ready, 1);

        wr(0, 0, 'h55); cycle(); set_idle();
        chk("t5_ready", gat_ready, 0);
        chk("t5_state", gat_status[31:29], S_LOAD);
        chk("t5_cnt", word_cnt, {5'd0, 5'd0, 5'd1});
        chk("t5_ebusy2", gat_status[28], 1);

        ld = 3'b111; cycle(); set_idle();
        cycle(); cycle(); cycle();
        chk("t6_run", gat_status[31:29], S_RUN);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_status", gat_status, 0);
        chk("t6_cnt", word_cnt, 0);
        chk("t6_wea", bif.core_wea, 0);
        chk("t6_ready", gat_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        cd = 1'b1; cycle(); cd = 1'b0;
        chk("t6_idle", gat_status[31:29], S_IDLE);
        chk("t6_noready", gat_ready, 0);
        cycle();

        // Random traffic, load-done and core-done against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                int a;
                bif.bus_ena[c] = ($urandom_range(0, 1) == 1);
                bif.bus_wea[c] = ($urandom_range(0, 3) != 0);
                a = int'($urandom_range(0, (1 << AW) - 1));
                if ($urandom_range(0, 7) != 0) a = a & ~3;
                bif.bus_addra[c*AW +: AW] = AW'(a);
                bif.bus_din[c*TW +: TW] = TW'($urandom);
                ld[c] = ($urandom_range(0, 49) == 0);
            end
            cd = ($urandom_range(0, 9) == 0);
            cycle();
        end
        set_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
